// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ==== rst_seq_pkg : state encodings and default parameters for rst_seq | rev 1.0 ====
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam int c_DEF_NUM_SRC       = 2;
  localparam int c_DEF_NUM_CH        = 3;
  localparam int c_DEF_NUM_STAGES    = 2;
  localparam int c_DEF_FILTER_CYCLES = 4;
  localparam int c_DEF_GAP_CYCLES    = 2;

endpackage
`default_nettype wire

// File: rtl/rst_seq_sync.sv
`default_nettype none
// ==== rst_seq_sync : single-bit synchronizer, resets to 0 (request active) | rev 1.0 ====
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = c_DEF_NUM_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ==== rst_seq : filtered, staggered release of NUM_CH active-low resets | rev 1.0 ====
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_SRC       = c_DEF_NUM_SRC,
  parameter int NUM_CH        = c_DEF_NUM_CH,
  parameter int NUM_STAGES    = c_DEF_NUM_STAGES,
  parameter int FILTER_CYCLES = c_DEF_FILTER_CYCLES,
  parameter int GAP_CYCLES    = c_DEF_GAP_CYCLES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] REQ_N,
  input  logic               CAUSE_CLR,
  output logic [NUM_CH-1:0]  RST_OUT_N,
  output logic               SEQ_DONE,
  output logic [NUM_SRC-1:0] SRC_CAUSE
);

  localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FILT_W-1:0] c_FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [GAP_W-1:0]  c_GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CH_W-1:0]   c_CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] c_CH0       = NUM_CH'(1);

  generate
    if (NUM_STAGES < 2 || NUM_SRC < 1 || NUM_CH < 1 || FILTER_CYCLES < 1 || GAP_CYCLES < 1)
    begin : g_param_err
      $error("rst_seq: illegal parameter set");
    end
  endgenerate

  logic [NUM_SRC-1:0] w_req_sync;
  logic [NUM_SRC-1:0] w_req_act;
  logic               w_any_req;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      rst_seq_sync #(
        .NUM_STAGES(NUM_STAGES)
      ) u_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (REQ_N[i]),
        .q_o  (w_req_sync[i])
      );
    end
  endgenerate

  assign w_req_act = ~w_req_sync;
  assign w_any_req = |w_req_act;

  state_e              state_q, state_d;
  logic [FILT_W-1:0]   filt_q, filt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   rst_out_q, rst_out_d;
  logic                done_q, done_d;
  logic [NUM_SRC-1:0]  cause_q, cause_d;

  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    gap_d     = gap_q;
    ch_d      = ch_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    cause_d   = CAUSE_CLR ? '0 : cause_q;

    if (w_any_req) begin
      // Sources are only blamed when they pull an already-progressing sequence back.
      if (state_q != HOLD) begin
        cause_d = cause_d | w_req_act;
      end
      state_d   = HOLD;
      filt_d    = '0;
      gap_d     = '0;
      ch_d      = '0;
      rst_out_d = '0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        HOLD, FILTER: begin
          // The HOLD exit edge is itself the first clear sample of the window.
          if (filt_q == c_FILT_LAST) begin
            filt_d    = '0;
            gap_d     = '0;
            ch_d      = '0;
            rst_out_d = c_CH0;
            state_d   = (ch_d == c_CH_LAST) ? RUN : RELEASE;
            done_d    = (ch_d == c_CH_LAST);
          end else begin
            filt_d  = filt_q + 1'b1;
            state_d = FILTER;
          end
        end
        RELEASE: begin
          if (gap_q == c_GAP_LAST) begin
            gap_d     = '0;
            ch_d      = ch_q + 1'b1;
            rst_out_d = (rst_out_q << 1) | c_CH0;
            if (ch_d == c_CH_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HOLD;
      filt_q    <= '0;
      gap_q     <= '0;
      ch_q      <= '0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      gap_q     <= gap_d;
      ch_q      <= ch_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  assign RST_OUT_N = rst_out_q;
  assign SEQ_DONE  = done_q;
  assign SRC_CAUSE = cause_q;

endmodule
`default_nettype wire
